// File: rtl/codec_intf_if.sv
// Signal bundle between codec_intf and its surroundings (codec pins plus equalizer core samples).
// The master modport is the codec_intf view; the slave modport is the codec/core view.
interface codec_intf_if;
  logic        SDout;
  logic [15:0] lft_out;
  logic [15:0] rht_out;
  logic        MCLK;
  logic        SCLK;
  logic        LRCLK;
  logic        RSTn;
  logic        SDin;
  logic [15:0] lft_in;
  logic [15:0] rht_in;
  logic        valid;

  modport master (
    input  SDout, lft_out, rht_out,
    output MCLK, SCLK, LRCLK, RSTn, SDin, lft_in, rht_in, valid
  );

  modport slave (
    output SDout, lft_out, rht_out,
    input  MCLK, SCLK, LRCLK, RSTn, SDin, lft_in, rht_in, valid
  );
endinterface

// File: rtl/codec_intf.sv
// I2S codec interface: one 10-bit frame counter derives MCLK/SCLK/LRCLK, holds the codec
// in reset for one frame, deserializes ADC samples and serializes DAC samples.
module codec_intf (
  input  logic         clk,
  input  logic         rst_n,
  codec_intf_if.master bus
);

  typedef enum logic {
    CODEC_HOLD = 1'b0,
    CODEC_RUN  = 1'b1
  } codec_state_t;

  codec_state_t state_q, state_d;

  logic [9:0]  cnt_q, cnt_d;
  logic [31:0] rx_q, rx_d;
  logic [31:0] tx_q, tx_d;
  logic [15:0] lft_in_q, lft_in_d;
  logic [15:0] rht_in_q, rht_in_d;
  logic        valid_q, valid_d;

  logic rise_evt;
  logic fall_evt;
  logic frame_cap;
  logic tx_load;
  logic hold_done;

  assign rise_evt  = (cnt_q[4:0] == 5'h0F);
  assign fall_evt  = (cnt_q[4:0] == 5'h1F);
  assign frame_cap = (cnt_q == 10'h00F);
  assign tx_load   = (cnt_q == 10'h01F);
  assign hold_done = (cnt_q == 10'h3FF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= CODEC_HOLD;
      cnt_q    <= '0;
      rx_q     <= '0;
      tx_q     <= '0;
      lft_in_q <= '0;
      rht_in_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rx_q     <= rx_d;
      tx_q     <= tx_d;
      lft_in_q <= lft_in_d;
      rht_in_q <= rht_in_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 10'd1;
    rx_d     = rx_q;
    tx_d     = tx_q;
    lft_in_d = lft_in_q;
    rht_in_d = rht_in_q;
    valid_d  = 1'b0;

    // Codec stays in reset for one full frame so it sees MCLK before release.
    if (state_q == CODEC_HOLD && hold_done) begin
      state_d = CODEC_RUN;
    end

    if (rise_evt) begin
      rx_d = {rx_q[30:0], bus.SDout};
    end

    // The capture uses the word including this edge's shift: the right LSB arrives now.
    if (frame_cap) begin
      lft_in_d = rx_d[31:16];
      rht_in_d = rx_d[15:0];
      valid_d  = (state_q == CODEC_RUN);
    end

    if (tx_load) begin
      tx_d = {bus.lft_out, bus.rht_out};
    end else if (fall_evt) begin
      tx_d = {tx_q[30:0], 1'b0};
    end
  end

  assign bus.MCLK   = cnt_q[1];
  assign bus.SCLK   = cnt_q[4];
  assign bus.LRCLK  = cnt_q[9];
  assign bus.RSTn   = (state_q == CODEC_RUN);
  assign bus.SDin   = tx_q[31];
  assign bus.lft_in = lft_in_q;
  assign bus.rht_in = rht_in_q;
  assign bus.valid  = valid_q;

endmodule

// File: doc/codec_intf.md
Name: codec_intf

Overview:
- Serial interface between the stereo audio codec (I2S, 16-bit, 2 channels) and the equalizer core.
- Generates the codec clocks MCLK, SCLK and LRCLK, and holds the codec reset.
- Receive path: deserializes ADC data into parallel left/right samples and pulses `valid` once per frame. These are the `lft_in`, `rht_in` and `valid` inputs of the equalizer core.
- Transmit path: serializes the core's `lft_out`/`rht_out` back to the codec DAC.

Parameters:
- None. Frame geometry is fixed: 1024 clk per LRCLK period, 32 clk per SCLK period, 4 clk per MCLK period.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- SDout  input  1  serial ADC data from codec.
- lft_out  input  16  left DAC sample from equalizer core.
- rht_out  input  16  right DAC sample from equalizer core.
- MCLK  output  1  codec master clock, clk/4.
- SCLK  output  1  serial bit clock, clk/32.
- LRCLK  output  1  frame clock, clk/1024; 0 = left half, 1 = right half.
- RSTn  output  1  codec reset, active low.
- SDin  output  1  serial DAC data to codec.
- lft_in  output  16  received left sample.
- rht_in  output  16  received right sample.
- valid  output  1  one-clk pulse: new `lft_in`/`rht_in` pair available.

Behaviour:
- Clock: one clock; reset is asynchronous and active-low. Ports are named `clk` and `rst_n`.
- Reset values: cnt=0, MCLK=0, SCLK=0, LRCLK=0, RSTn=0, SDin=0, lft_in=0, rht_in=0, valid=0, both shift registers = 0.
- Counter: 10-bit free-running cnt increments every clk and wraps 0x3FF->0x000.
  - Counter runs during codec reset (the codec needs MCLK while held in reset).
  - MCLK = cnt[1], SCLK = cnt[4], LRCLK = cnt[9]. All are flop outputs, so glitch-free.
- Events, in clk domain:
  - rise_evt when cnt[4:0]==5'h0F: SCLK rises on this edge.
  - fall_evt when cnt[4:0]==5'h1F: SCLK falls on this edge.
- RSTn: goes 1 on the first edge with cnt==0x3FF after reset (1024 clk after rst_n deasserts), then stays 1 until rst_n asserts again.
- Receive (I2S, MSB one SCLK after LRCLK edge):
  - 32-bit rx shift register shifts SDout into bit 0 on every rise_evt.
  - On the edge with cnt==0x00F, using the post-shift value: lft_in <= bits[31:16], rht_in <= bits[15:0].
  - On that same edge valid <= RSTn; valid is 0 on all other edges. This gives exactly one pulse per 1024 clk.
- Transmit:
  - 32-bit tx shift register; SDin = tx[31], registered.
  - On the edge with cnt==0x01F: tx <= {lft_out, rht_out}. This places the left MSB one SCLK after LRCLK falls.
  - On every other fall_evt: tx <= tx<<1. The right MSB is then driven at the cnt==0x21F edge, one SCLK after LRCLK rises.
  - lft_out/rht_out are sampled only at cnt==0x01F; changes at other times are ignored.
- Latency: a frame's samples are driven out on SDin starting at the next cnt==0x01F load. This is independent of equalizer latency; the core output present at load time is sent.
- Simultaneous events: rise_evt and fall_evt never coincide. The load at 0x01F replaces that fall_evt's shift.
- Reset mid-operation: everything returns to reset values immediately. Codec RSTn drops, and the full 1024-clk RSTn delay is re-run after deassertion.

Test Plan:
- Reset/clocks: assert rst_n for 5 clk, release.
  - All outputs 0 during reset.
  - MCLK toggles every 2 clk, SCLK every 16 clk, LRCLK every 512 clk.
  - RSTn rises exactly 1024 clk after release.
- Receive: codec model drives left=0xA5C3, right=0x1234 in I2S timing on SDout.
  - At cnt==0x00F, lft_in=0xA5C3, rht_in=0x1234.
  - valid is high for exactly 1 clk per frame.
  - No valid before RSTn=1.
- Transmit: hold lft_out=0x8001, rht_out=0x7FFE.
  - SDin bits captured on SCLK rise reconstruct left=0x8001 in the LRCLK-low half and right=0x7FFE in the LRCLK-high half.
  - Each MSB is driven one SCLK after the LRCLK edge.
- Sample-time isolation: change lft_out from 0x0F0F to 0xF0F0 at cnt==0x100, mid-frame.
  - SDin finishes the current frame with 0x0F0F.
  - 0xF0F0 appears in the next frame.
- Loopback: tie SDin to SDout through a model with one frame of delay and stream 8 random pairs.
  - Each lft_in/rht_in matches the transmitted pair, bit-exact, at the expected frame offset.
- Reset mid-frame: assert rst_n at cnt==0x2A0 for 3 clk.
  - Outputs return to reset values and RSTn=0.
  - After release, no valid and RSTn=0 for 1024 clk; normal frames resume afterwards.
